// File: rtl/seg_disp_pkg.sv
// Shared constants for the serial 7-segment display driver: FSM encoding,
// blank pattern and the active-low hex-to-segment table.
package seg_disp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; the dp bit is added by the encoder.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_hex_encode.sv
// One digit of text-mode encoding: nibble plus decimal point to an active-low
// segment byte, forced fully dark when the digit is in its blank phase.
module seg_hex_encode
  import seg_disp_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       point,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    if (blank) seg = SEG_BLANK;
    else       seg = {~point, hex_to_seg(hex)};
  end

endmodule

// File: rtl/seg_serial_disp.sv
// Serialises one byte per digit into an external shift register, MSB first,
// then latches it onto the display.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | display enabled, waiting for start
//   ST_LOAD  | capture frame, clear external register (1 cycle)
//   ST_SHIFT | clock out 8*DIGITS bits, DIV cycles low then DIV high
//   ST_LATCH | seg_clk low, display disabled (1 cycle), then done
module seg_serial_disp
  import seg_disp_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     les,
  input  logic [DIGITS-1:0]     points,
  input  logic                  flash,
  input  logic [8*DIGITS-1:0]   seg_map,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_clrn,
  output logic                  seg_pen,
  output logic                  busy,
  output logic                  done
);

  localparam int NBITS = 8 * DIGITS;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int DW    = $clog2(DIV + 1);

  localparam logic [BW-1:0] BIT_LOAD = BW'(NBITS);
  localparam logic [BW-1:0] BIT_TC   = BW'(1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(DIV);
  localparam logic [DW-1:0] DIV_TC   = DW'(1);

  logic [1:0]       state;
  logic [NBITS-1:0] frame;
  logic [NBITS-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             clk_q;
  logic             live;
  logic             done_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [7:0] enc;

    seg_hex_encode u_enc (
      .hex   (hexs[4*i +: 4]),
      .point (points[i]),
      .blank (les[i] & flash),
      .seg   (enc)
    );

    assign frame[8*i +: 8] = mode ? enc : seg_map[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      clk_q   <= 1'b0;
      live    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // live holds the display off/cleared for the reset cycle itself
      live   <= 1'b1;
      done_q <= (state == ST_LATCH);
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg   <= frame;
          bit_cnt <= BIT_LOAD;
          div_cnt <= DIV_LOAD;
          clk_q   <= 1'b0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_TC) begin
            div_cnt <= DIV_LOAD;
            clk_q   <= ~clk_q;
            // falling edge: advance to the next bit
            if (clk_q) begin
              shreg   <= {shreg[NBITS-2:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == BIT_TC) state <= ST_LATCH;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_LATCH: begin
          clk_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign seg_clk  = clk_q;
  assign seg_sout = shreg[NBITS-1];
  assign seg_clrn = live & (state != ST_LOAD);
  assign seg_pen  = live & (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_seg_serial_disp.sv
// Bench for seg_serial_disp: two 2-digit instances (DIV=1 and DIV=3) share
// stimulus; frames are rebuilt from seg_sout on each seg_clk rising edge.
module tb_seg_serial_disp;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [7:0]  hexs;
  logic [1:0]  les;
  logic [1:0]  points;
  logic        flash;
  logic [15:0] seg_map;

  logic seg_clk1, seg_sout1, seg_clrn1, seg_pen1, busy1, done1;
  logic seg_clk3, seg_sout3, seg_clrn3, seg_pen3, busy3, done3;

  int total  = 0;
  int passed = 0;

  seg_serial_disp #(.DIGITS(2), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hexs(hexs), .les(les),
    .points(points), .flash(flash), .seg_map(seg_map),
    .seg_clk(seg_clk1), .seg_sout(seg_sout1), .seg_clrn(seg_clrn1),
    .seg_pen(seg_pen1), .busy(busy1), .done(done1)
  );

  seg_serial_disp #(.DIGITS(2), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .hexs(hexs), .les(les),
    .points(points), .flash(flash), .seg_map(seg_map),
    .seg_clk(seg_clk3), .seg_sout(seg_sout3), .seg_clrn(seg_clrn3),
    .seg_pen(seg_pen3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [7:0]  hexs;
    logic [1:0]  les;
    logic [1:0]  points;
    logic        flash;
    logic [15:0] seg_map;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  logic [15:0] fr1, fr3;
  int d1, d3, clk_bad, pen_bad, sout_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pulse start, then watch both instances until both report done.
  // k = 0 is the LOAD cycle. With scramble set, all inputs flip mid-shift.
  task automatic run_frame(input bit scramble);
    logic p1, p3, ps3;
    int   run;
    bit   seen_rise;
    fr1 = '0; fr3 = '0; d1 = -1; d3 = -1;
    clk_bad = 0; pen_bad = 0; sout_bad = 0;
    p1 = 1'b0; p3 = 1'b0; ps3 = 1'b0; run = 0; seen_rise = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 250 && (d1 < 0 || d3 < 0); k++) begin
      if (k > 0) @(negedge clk);
      if (seg_clk1 && !p1) fr1 = {fr1[14:0], seg_sout1};
      if (seg_clk3 && !p3) fr3 = {fr3[14:0], seg_sout3};
      if (busy3 && seg_pen3) pen_bad++;
      if (p3 && seg_clk3 && (seg_sout3 !== ps3)) sout_bad++;
      if (seg_clk3 !== p3) begin
        if (seen_rise && run != 3) clk_bad++;
        if (seg_clk3) seen_rise = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      if (done1 && d1 < 0) d1 = k;
      if (done3 && d3 < 0) d3 = k;
      p1 = seg_clk1; p3 = seg_clk3; ps3 = seg_sout3;
      if (scramble && k == 5) begin
        hexs = ~hexs; seg_map = ~seg_map; flash = ~flash;
        les = ~les; points = ~points; mode = ~mode;
      end
    end
  endtask

  initial begin
    int dcount, first_done, reload_at, second_done, stray_clr;

    //            mode  hexs    les    points flash seg_map   expected frame
    vecs[0] = '{1'b1, 8'h80, 2'b00, 2'b00, 1'b0, 16'h0000, 16'h80C0};
    vecs[1] = '{1'b1, 8'h88, 2'b01, 2'b10, 1'b1, 16'h0000, 16'h00FF};
    vecs[2] = '{1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 16'hA53C, 16'hA53C};
    vecs[3] = '{1'b0, 8'h12, 2'b11, 2'b11, 1'b1, 16'hA53C, 16'hA53C};
    vecs[4] = '{1'b1, 8'hF1, 2'b00, 2'b01, 1'b1, 16'h0000, 16'h8E79};
    vecs[5] = '{1'b1, 8'h3A, 2'b10, 2'b00, 1'b0, 16'hFFFF, 16'hB088};
    vecs[6] = '{1'b1, 8'hE5, 2'b11, 2'b00, 1'b1, 16'h0000, 16'hFFFF};

    rst = 1'b1; start = 1'b0; mode = 1'b0; hexs = '0; les = '0;
    points = '0; flash = 1'b0; seg_map = '0;

    repeat (3) @(negedge clk);
    check("reset_outs_div1", {seg_clk1, seg_sout1, seg_clrn1, seg_pen1, busy1, done1}, 6'b0);
    check("reset_outs_div3", {seg_clk3, seg_sout3, seg_clrn3, seg_pen3, busy3, done3}, 6'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_div1", {seg_clrn1, seg_pen1, busy1}, 3'b110);
    check("post_reset_div3", {seg_clrn3, seg_pen3, busy3}, 3'b110);

    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].mode; hexs = vecs[i].hexs; les = vecs[i].les;
      points = vecs[i].points; flash = vecs[i].flash; seg_map = vecs[i].seg_map;
      run_frame(1'b1);
      check($sformatf("v%0d_frame_div1", i), fr1, vecs[i].exp);
      check($sformatf("v%0d_frame_div3", i), fr3, vecs[i].exp);
      check($sformatf("v%0d_done_at_div1", i), d1, 34);
      check($sformatf("v%0d_done_at_div3", i), d3, 98);
      check($sformatf("v%0d_clk_phase_div3", i), clk_bad, 0);
      check($sformatf("v%0d_pen_in_shift_div3", i), pen_bad, 0);
      check($sformatf("v%0d_sout_stable_div3", i), sout_bad, 0);
    end

    // Reset in the middle of the shift: abandon the frame, no done.
    mode = vecs[0].mode; hexs = vecs[0].hexs; les = vecs[0].les;
    points = vecs[0].points; flash = vecs[0].flash; seg_map = vecs[0].seg_map;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("midshift_busy_div1", busy1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outs_div1", {seg_clk1, seg_sout1, seg_clrn1, seg_pen1, busy1, done1}, 6'b0);
    check("midreset_outs_div3", {seg_clk3, seg_sout3, seg_clrn3, seg_pen3, busy3, done3}, 6'b0);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done1 || done3 || busy1 || busy3) dcount++;
    end
    check("midreset_no_done_or_busy", dcount, 0);
    check("midreset_idle_pen", {seg_pen1, seg_pen3, seg_clrn1, seg_clrn3}, 4'b1111);

    // start held high: back-to-back frames on DUT1, ignored while busy.
    first_done = -1; reload_at = -1; second_done = -1; stray_clr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    check("hold_load_clrn_div1", {seg_clrn1, busy1}, 2'b01);
    for (int k = 1; k < 76; k++) begin
      @(negedge clk);
      if (done1) begin
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (!seg_clrn1) begin
        if (first_done < 0) stray_clr++;
        else if (reload_at < 0) reload_at = k;
      end
      if (k == 36) start = 1'b0;
    end
    check("hold_first_done", first_done, 34);
    check("hold_reload_load", reload_at, 35);
    check("hold_second_done", second_done, 69);
    check("hold_start_in_shift_ignored", stray_clr, 0);

    dcount = 0;
    for (int k = 0; k < 200 && busy3; k++) begin
      @(negedge clk);
      dcount++;
    end
    check("hold_div3_returns_idle", busy3, 1'b0);
    @(negedge clk);
    check("final_idle_div1", {busy1, seg_pen1}, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
